uio_bank_arbiter: RTL
=====================

Name: uio_bank_arbiter

Overview:
- Shares the 8-bit bidirectional uio pad bank (uio_out/uio_oe/uio_in) between two on-chip requesters, A and B.
- Uses round-robin arbitration with a req/gnt handshake.
- Inserts a forced turnaround (all pads input, uio_oe=0) between owners so pads never see contention.
- Sits between the project top level and the uio pins; replaces the static tie-off of uio_out/uio_oe to ground.

Parameters:
- WIDTH, 8, pad bank width.
- TURN_CYCLES, 1, turnaround length in cycles (legal range 1..15).
- MAX_HOLD, 16, maximum ownership cycles under contention (used only with ARB_TIMEOUT_EN; legal range 1..255).

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  2  request; bit0=A, bit1=B; held high for the whole ownership.
- data_a  input  WIDTH  A's drive value.
- oe_a  input  WIDTH  A's per-pin output enable.
- data_b  input  WIDTH  B's drive value.
- oe_b  input  WIDTH  B's per-pin output enable.
- gnt  output  2  grant, one-hot or zero, registered.
- busy  output  1  high in any state other than IDLE.
- preempt  output  2  one-cycle pulse when the owner is forcibly released.
- uio_out  output  WIDTH  to pads, registered.
- uio_oe  output  WIDTH  to pads, registered.
- uio_in  input  WIDTH  from pads.
- rd_data  output  WIDTH  uio_in registered one cycle, for both requesters.

Behaviour:
- Reset (async on rst high):
  - state=IDLE; gnt=0, busy=0, preempt=0.
  - uio_out=0, uio_oe=0, rd_data=0.
  - last_owner=B, so A wins the first tie.
  - turn counter=0.
- States: IDLE, TURN, OWN_A, OWN_B. TURN carries a registered target owner.
- IDLE:
  - Sample req at each edge. If nonzero, go to TURN.
  - Target is the sole requester, or on a tie the requester that is not last_owner.
  - uio_oe=0.
- TURN:
  - uio_oe=0 and gnt=0 for exactly TURN_CYCLES cycles.
  - After the last cycle: if target's req is still high, go to OWN_target, set gnt[target]=1 and last_owner=target.
  - Otherwise go to IDLE, or directly to a new TURN for the other requester if its req is high; last_owner is unchanged.
- Grant latency (TURN_CYCLES=1): req rises before edge k → TURN after edge k → gnt high after edge k+1. No grant is possible in less than 1+TURN_CYCLES edges.
- OWN_x:
  - Each edge registers uio_out<=data_x and uio_oe<=oe_x.
  - Pads follow owner inputs with a 1-cycle lag. The first pad drive appears the edge after gnt rises.
- Release:
  - req[x] sampled low in OWN_x → gnt=0 and uio_oe=0 at that same edge; uio_out holds its last value.
  - Next state is TURN (target = other requester if requesting, else IDLE).
  - The owner's data is never driven after gnt falls.
- Re-request: an owner that releases and re-requests while the other is idle passes through IDLE/TURN again, with no back-to-back grant.
- rd_data<=uio_in every cycle regardless of state.
- Invariants:
  - gnt is never 2'b11.
  - uio_oe is 0 in IDLE and TURN, and for at least TURN_CYCLES cycles between any two different owners.
- Reset mid-ownership: immediate drop to reset values, including uio_oe=0 without waiting for an edge.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (8 bits) counts cycles in OWN_x while the other req is high.
  - On reaching MAX_HOLD: gnt[x]=0, uio_oe=0, preempt[x]=1 for one cycle, go to TURN with target = other requester.
  - The counter clears on entry to OWN and whenever the other req is low.
- Not defined: ownership is unbounded, preempt is tied 0, and no hold counter exists.

Test Plan:
- Reset, then req=01: gnt=01 two edges after req. Drive data_a=0xA5, oe_a=0xFF: next edge uio_out=0xA5, uio_oe=0xFF. busy=1.
- req=11 from IDLE after reset: A granted first. Drop req[0]: gnt→00 and uio_oe→0x00 that edge; exactly 1 cycle later gnt=10 and B's data appears one edge after that.
- Turnaround check, TURN_CYCLES=3: count uio_oe==0 cycles between A release and B drive; must be ≥3. gnt never 11 over a 1000-cycle random req run.
- req[1] pulses high for one cycle only during TURN: no grant issued; return to IDLE; last_owner unchanged.
- Assert rst while B owns with uio_oe=0x0F: uio_oe=0, gnt=0, rd_data=0 immediately. After release of rst, req=11 grants A.
- ARB_TIMEOUT_EN, MAX_HOLD=4: A holds req with B requesting → after 4 cycles preempt=01 for 1 cycle, gnt 01→00→10. Without the macro, A holds for 100 cycles and preempt stays 0.

Source files
------------

// File: rtl/uio_bank_arbiter.sv
// Round-robin arbiter sharing the uio pad bank between requesters A and B, with a
// forced all-input turnaround between owners. Define ARB_TIMEOUT_EN to bound ownership under contention.
module uio_bank_arbiter #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] oe_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] oe_b,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       preempt,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] rd_data
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("uio_bank_arbiter: TURN_CYCLES out of range 1..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("uio_bank_arbiter: MAX_HOLD out of range 1..255");
  end

  typedef enum logic [1:0] {IDLE, TURN, OWN_A, OWN_B} state_t;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  state_t     state;
  logic       target;      // 0 = A, 1 = B
  logic       last_owner;  // 0 = A, 1 = B
  logic [3:0] turn_cnt;

  // Owner-relative views so OWN_A and OWN_B share one code path
  logic             own_b;
  logic             own_req;
  logic             other_req;
  logic [WIDTH-1:0] own_data;
  logic [WIDTH-1:0] own_oe;

  assign own_b     = (state == OWN_B);
  assign own_req   = req[own_b];
  assign other_req = req[~own_b];
  assign own_data  = own_b ? data_b : data_a;
  assign own_oe    = own_b ? oe_b : oe_a;
  assign busy      = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic [1:0] preempt_r;
  assign preempt = preempt_r;
`else
  assign preempt = 2'b00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      target     <= 1'b0;
      last_owner <= 1'b1;
      turn_cnt   <= 4'd0;
      gnt        <= 2'b00;
      uio_out    <= '0;
      uio_oe     <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt   <= 8'd0;
      preempt_r  <= 2'b00;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      preempt_r <= 2'b00;
`endif
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state    <= TURN;
            turn_cnt <= 4'd0;
            target   <= (req == 2'b11) ? ~last_owner : req[1];
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            turn_cnt <= 4'd0;
            if (req[target]) begin
              state      <= target ? OWN_B : OWN_A;
              gnt        <= target ? 2'b10 : 2'b01;
              last_owner <= target;
`ifdef ARB_TIMEOUT_EN
              hold_cnt   <= 8'd0;
`endif
            end else if (req[~target]) begin
              // Target gave up during the turnaround; restart it for the other side
              target <= ~target;
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt + 4'd1;
          end
        end
        OWN_A, OWN_B: begin
          if (!own_req) begin
            // Pads go input on the same edge the grant drops; uio_out keeps its value
            gnt    <= 2'b00;
            uio_oe <= '0;
            if (other_req) begin
              state    <= TURN;
              target   <= ~own_b;
              turn_cnt <= 4'd0;
            end else begin
              state <= IDLE;
            end
`ifdef ARB_TIMEOUT_EN
          end else if (other_req && hold_cnt == HOLD_LAST) begin
            gnt       <= 2'b00;
            uio_oe    <= '0;
            preempt_r <= own_b ? 2'b10 : 2'b01;
            state     <= TURN;
            target    <= ~own_b;
            turn_cnt  <= 4'd0;
            hold_cnt  <= 8'd0;
`endif
          end else begin
            uio_out  <= own_data;
            uio_oe   <= own_oe;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= other_req ? hold_cnt + 8'd1 : 8'd0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= uio_in;
  end

endmodule
